// File: rtl/ex_alu_iter.sv
// rtl/ex_alu_iter.sv - Registered execute-stage ALU with iterative MULTU/DIVU and HI register; optional overflow trap via EX_ALU_OVF_EN
module ex_alu_iter #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OP_W       = 8,
    parameter int SEL_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  flush_i,
    input  logic [OP_W-1:0]       aluop_i,
    input  logic [SEL_W-1:0]      alusel_i,
    input  logic [WIDTH-1:0]      reg1_i,
    input  logic [WIDTH-1:0]      reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    output logic                  valid_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [WIDTH-1:0]      wdata_o,
    output logic [WIDTH-1:0]      hi_o,
    output logic                  ovf_o
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [OP_W-1:0] OP_AND   = OP_W'('h24);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'('h25);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'('h26);
    localparam logic [OP_W-1:0] OP_NOR   = OP_W'('h27);
    localparam logic [OP_W-1:0] OP_ADDU  = OP_W'('h21);
    localparam logic [OP_W-1:0] OP_SUBU  = OP_W'('h23);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'('h2A);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'('h2B);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'('h20);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'('h22);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'('h7C);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'('h02);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'('h03);
    localparam logic [OP_W-1:0] OP_MULTU = OP_W'('h19);
    localparam logic [OP_W-1:0] OP_DIVU  = OP_W'('h1B);
    localparam logic [OP_W-1:0] OP_MFHI  = OP_W'('h10);

    localparam logic [SEL_W-1:0] SEL_LOGIC  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_SHIFT  = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_ARITH  = SEL_W'(3);
    localparam logic [SEL_W-1:0] SEL_MULDIV = SEL_W'(4);
    localparam logic [SEL_W-1:0] SEL_MOVE   = SEL_W'(5);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        cnt;
    logic [WIDTH-1:0]        acc_hi;
    logic [WIDTH-1:0]        acc_lo;
    logic [WIDTH-1:0]        opnd;
    logic                    is_div;
    logic [REG_ADDR_W-1:0]   lat_wd;
    logic                    lat_wreg;
    logic [WIDTH-1:0]        hi_q;

    logic                    accept;
    logic                    start_md;
    logic                    div_zero;
    logic [SH_W-1:0]         shamt;
    logic [WIDTH-1:0]        sum;
    logic [WIDTH-1:0]        diff;
    logic [WIDTH-1:0]        res;
    logic                    ovf_c;

    logic [WIDTH:0]          mul_sum;
    logic [WIDTH:0]          rem_sh;
    logic [WIDTH:0]          trial;
    logic [WIDTH-1:0]        step_hi;
    logic [WIDTH-1:0]        step_lo;

    assign ready_o  = (state == S_IDLE);
    assign accept   = valid_i && ready_o && !flush_i;
    assign start_md = (alusel_i == SEL_MULDIV) && ((aluop_i == OP_MULTU) || (aluop_i == OP_DIVU));
    assign div_zero = (aluop_i == OP_DIVU) && (reg2_i == '0);
    assign shamt    = reg1_i[SH_W-1:0];
    assign sum      = reg1_i + reg2_i;
    assign diff     = reg1_i - reg2_i;
    assign hi_o     = hi_q;

    // Single-cycle result selection; mul/div opcodes produce 0 here since they complete later
    always_comb begin
        res = '0;
        case (alusel_i)
            SEL_LOGIC: begin
                case (aluop_i)
                    OP_AND:  res = reg1_i & reg2_i;
                    OP_OR:   res = reg1_i | reg2_i;
                    OP_XOR:  res = reg1_i ^ reg2_i;
                    OP_NOR:  res = ~(reg1_i | reg2_i);
                    default: res = '0;
                endcase
            end
            SEL_SHIFT: begin
                case (aluop_i)
                    OP_SLL:  res = reg2_i << shamt;
                    OP_SRL:  res = reg2_i >> shamt;
                    OP_SRA:  res = $signed(reg2_i) >>> shamt;
                    default: res = '0;
                endcase
            end
            SEL_ARITH: begin
                case (aluop_i)
                    OP_ADDU, OP_ADD: res = sum;
                    OP_SUBU, OP_SUB: res = diff;
                    OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
                    OP_SLTU: res = {{(WIDTH-1){1'b0}}, (reg1_i < reg2_i)};
                    default: res = '0;
                endcase
            end
            SEL_MOVE: begin
                if (aluop_i == OP_MFHI) begin
                    res = hi_q;
                end
            end
            default: res = '0;
        endcase
    end

`ifdef EX_ALU_OVF_EN
    // Signed overflow: operands agree in sign (add) or differ (sub) and the result sign flips
    always_comb begin
        ovf_c = 1'b0;
        if (alusel_i == SEL_ARITH) begin
            if (aluop_i == OP_ADD) begin
                ovf_c = (reg1_i[WIDTH-1] == reg2_i[WIDTH-1]) && (sum[WIDTH-1] != reg1_i[WIDTH-1]);
            end else if (aluop_i == OP_SUB) begin
                ovf_c = (reg1_i[WIDTH-1] != reg2_i[WIDTH-1]) && (diff[WIDTH-1] != reg1_i[WIDTH-1]);
            end
        end
    end
`else
    assign ovf_c = 1'b0;
`endif

    // One iteration step: shift-add for MULTU on {hi,lo}, restoring subtract for DIVU on {rem,quo}
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
        trial   = rem_sh - {1'b0, opnd};
        if (is_div) begin
            if (!trial[WIDTH]) begin
                step_hi = trial[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = rem_sh[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: divide by zero skips iteration and goes straight to DONE
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept && start_md) begin
                    state_nx = div_zero ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    state_nx = S_IDLE;
                end else if (cnt == CNT_W'(WIDTH-1)) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Iteration datapath: latch operands on accept, then step once per BUSY cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            lat_wd   <= '0;
            lat_wreg <= 1'b0;
        end else if (state == S_IDLE) begin
            if (accept && start_md) begin
                cnt      <= '0;
                is_div   <= (aluop_i == OP_DIVU);
                lat_wd   <= wd_i;
                lat_wreg <= wreg_i;
                if (aluop_i == OP_DIVU) begin
                    opnd <= reg2_i;
                    if (div_zero) begin
                        acc_hi <= reg1_i;
                        acc_lo <= '1;
                    end else begin
                        acc_hi <= '0;
                        acc_lo <= reg1_i;
                    end
                end else begin
                    opnd   <= reg1_i;
                    acc_hi <= '0;
                    acc_lo <= reg2_i;
                end
            end
        end else if (state == S_BUSY && !flush_i) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + 1'b1;
        end
    end

    // Result registers: single-cycle ops retire from IDLE, mul/div retire from DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            wd_o    <= '0;
            wreg_o  <= 1'b0;
            wdata_o <= '0;
            hi_q    <= '0;
            ovf_o   <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            ovf_o   <= 1'b0;
            if (state == S_IDLE && accept && !start_md) begin
                valid_o <= 1'b1;
                wd_o    <= wd_i;
                wreg_o  <= wreg_i && !ovf_c;
                wdata_o <= res;
                ovf_o   <= ovf_c;
            end else if (state == S_DONE && !flush_i) begin
                valid_o <= 1'b1;
                wd_o    <= lat_wd;
                wreg_o  <= lat_wreg;
                wdata_o <= acc_lo;
                hi_q    <= acc_hi;
            end
        end
    end

endmodule

// File: tb/tb_ex_alu_iter.sv
// tb/tb_ex_alu_iter.sv - Directed self-checking bench for ex_alu_iter
module tb_ex_alu_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic        flush_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        valid_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic [31:0] hi_o;
    logic        ovf_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]  sel;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    ex_alu_iter dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .flush_i  (flush_i),
        .aluop_i  (aluop_i),
        .alusel_i (alusel_i),
        .reg1_i   (reg1_i),
        .reg2_i   (reg2_i),
        .wd_i     (wd_i),
        .wreg_i   (wreg_i),
        .valid_o  (valid_o),
        .wd_o     (wd_o),
        .wreg_o   (wreg_o),
        .wdata_o  (wdata_o),
        .hi_o     (hi_o),
        .ovf_o    (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        valid_i  = 1'b0;
        flush_i  = 1'b0;
        aluop_i  = 8'h00;
        alusel_i = 3'd0;
        reg1_i   = 32'h0;
        reg2_i   = 32'h0;
        wd_i     = 5'd0;
        wreg_i   = 1'b0;
    endtask

    task automatic drive_op(input logic [2:0] sel, input logic [7:0] op,
                            input logic [31:0] a, input logic [31:0] b, input logic [4:0] wd);
        valid_i  = 1'b1;
        flush_i  = 1'b0;
        alusel_i = sel;
        aluop_i  = op;
        reg1_i   = a;
        reg2_i   = b;
        wd_i     = wd;
        wreg_i   = 1'b1;
    endtask

    task automatic test_reset();
        drive_op(3'd1, 8'h25, 32'h1234_5678, 32'h0F0F_0F0F, 5'd9);
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_checks++;
        if ({wd_o, wreg_o, wdata_o, hi_o, ovf_o} !== 71'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: wd=%h wreg=%b wdata=%h hi=%h ovf=%b want all 0", wd_o, wreg_o, wdata_o, hi_o, ovf_o);
        end
        rst = 1'b0;
        drive_idle();
        tick();
        n_checks++;
        if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready_o); end
        n_checks++;
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_no_valid: got %b want 0", valid_o); end
    endtask

    task automatic test_back_to_back();
        drive_op(3'd1, 8'h25, 32'h0F0F_0000, 32'h0000_F0F0, 5'd3);
        tick();
        n_checks++;
        if (valid_o !== 1'b1 || wdata_o !== 32'h0F0F_F0F0 || wd_o !== 5'd3 || wreg_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_or: valid=%b wdata=%h wd=%0d wreg=%b want 1 0f0ff0f0 3 1", valid_o, wdata_o, wd_o, wreg_o);
        end
        drive_op(3'd2, 8'h03, 32'h0000_0004, 32'h8000_0000, 5'd4);
        tick();
        n_checks++;
        if (valid_o !== 1'b1 || wdata_o !== 32'hF800_0000 || wd_o !== 5'd4) begin
            n_fail++;
            $display("FAIL b2b_sra: valid=%b wdata=%h wd=%0d want 1 f8000000 4", valid_o, wdata_o, wd_o);
        end
        drive_idle();
        tick();
        n_checks++;
        if (valid_o !== 1'b0 || wdata_o !== 32'hF800_0000) begin
            n_fail++;
            $display("FAIL b2b_hold: valid=%b wdata=%h want 0 f8000000", valid_o, wdata_o);
        end
    endtask

    task automatic test_single_cycle_ops();
        vec_t vecs[11];
        vecs[0]  = '{3'd1, 8'h26, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
        vecs[1]  = '{3'd1, 8'h27, 32'h00FF_00FF, 32'h0F00_0000, 32'hF000_FF00};
        vecs[2]  = '{3'd3, 8'h23, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE};
        vecs[3]  = '{3'd3, 8'h21, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
        vecs[4]  = '{3'd3, 8'h2A, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vecs[5]  = '{3'd3, 8'h2B, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[6]  = '{3'd2, 8'h7C, 32'h0000_0024, 32'h0000_000F, 32'h0000_00F0};
        vecs[7]  = '{3'd2, 8'h02, 32'h0000_001F, 32'h8000_0000, 32'h0000_0001};
        vecs[8]  = '{3'd2, 8'h03, 32'h0000_001F, 32'h8000_0000, 32'hFFFF_FFFF};
        vecs[9]  = '{3'd1, 8'h3F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[10] = '{3'd0, 8'h25, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000};
        for (int i = 0; i < 11; i++) begin
            drive_op(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 10));
            tick();
            n_checks++;
            if (valid_o !== 1'b1 || wdata_o !== vecs[i].exp || wreg_o !== 1'b1 || wd_o !== 5'(i + 10)) begin
                n_fail++;
                $display("FAIL op_vec%0d: valid=%b wdata=%h wreg=%b wd=%0d want 1 %h 1 %0d",
                         i, valid_o, wdata_o, wreg_o, wd_o, vecs[i].exp, i + 10);
            end
        end
        drive_idle();
        tick();
        n_checks++;
        if (hi_o !== 32'h0) begin n_fail++; $display("FAIL op_hi_untouched: got %h want 0", hi_o); end
    endtask

    task automatic run_muldiv(input string name, input logic [7:0] op, input logic [31:0] a,
                              input logic [31:0] b, input int exp_lat,
                              input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int cyc;
        int low;
        drive_op(3'd4, op, a, b, 5'd21);
        tick();
        drive_idle();
        cyc = 0;
        low = 0;
        while (valid_o !== 1'b1 && cyc < 80) begin
            if (ready_o === 1'b0) low++;
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc != exp_lat || low != exp_lat) begin
            n_fail++;
            $display("FAIL %s_latency: valid after %0d edges, ready low %0d cycles, want %0d and %0d", name, cyc, low, exp_lat, exp_lat);
        end
        n_checks++;
        if (wdata_o !== exp_lo || hi_o !== exp_hi || wd_o !== 5'd21 || wreg_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_result: wdata=%h hi=%h wd=%0d wreg=%b want %h %h 21 1", name, wdata_o, hi_o, wd_o, wreg_o, exp_lo, exp_hi);
        end
        n_checks++;
        if (ready_o !== 1'b1) begin n_fail++; $display("FAIL %s_ready_after: got %b want 1", name, ready_o); end
        tick();
        n_checks++;
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL %s_pulse: valid still %b want 0", name, valid_o); end
    endtask

    task automatic test_multu();
        run_muldiv("multu", 8'h19, 32'hFFFF_FFFF, 32'h0000_0002, 33, 32'hFFFF_FFFE, 32'h0000_0001);
        drive_op(3'd5, 8'h10, 32'h0, 32'h0, 5'd6);
        tick();
        drive_idle();
        n_checks++;
        if (valid_o !== 1'b1 || wdata_o !== 32'h1 || wd_o !== 5'd6) begin
            n_fail++;
            $display("FAIL mfhi: valid=%b wdata=%h wd=%0d want 1 00000001 6", valid_o, wdata_o, wd_o);
        end
    endtask

    task automatic test_divu();
        run_muldiv("divu", 8'h1B, 32'd100, 32'd7, 33, 32'd14, 32'd2);
        run_muldiv("divzero", 8'h1B, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 32'd5);
    endtask

    task automatic test_flush();
        logic seen_valid;
        logic hi_moved;
        drive_op(3'd4, 8'h1B, 32'd200, 32'd3, 5'd22);
        tick();
        drive_idle();
        for (int i = 0; i < 9; i++) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || hi_o !== 32'd5) begin
            n_fail++;
            $display("FAIL flush_abort: valid=%b ready=%b hi=%h want 0 1 00000005", valid_o, ready_o, hi_o);
        end
        drive_op(3'd1, 8'h24, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd7);
        tick();
        drive_idle();
        n_checks++;
        if (valid_o !== 1'b1 || wdata_o !== 32'h0F00_0F00 || wd_o !== 5'd7) begin
            n_fail++;
            $display("FAIL flush_and: valid=%b wdata=%h wd=%0d want 1 0f000f00 7", valid_o, wdata_o, wd_o);
        end
        seen_valid = 1'b0;
        hi_moved   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid_o !== 1'b0) seen_valid = 1'b1;
            if (hi_o !== 32'd5) hi_moved = 1'b1;
        end
        n_checks++;
        if (seen_valid || hi_moved) begin
            n_fail++;
            $display("FAIL flush_quiet: late valid=%b hi changed=%b want 0 0", seen_valid, hi_moved);
        end
    endtask

    task automatic test_add_ovf();
        logic exp_ovf;
        logic exp_wreg;
`ifdef EX_ALU_OVF_EN
        exp_ovf  = 1'b1;
        exp_wreg = 1'b0;
`else
        exp_ovf  = 1'b0;
        exp_wreg = 1'b1;
`endif
        drive_op(3'd3, 8'h20, 32'h7FFF_FFFF, 32'h0000_0001, 5'd8);
        tick();
        drive_idle();
        n_checks++;
        if (valid_o !== 1'b1 || wdata_o !== 32'h8000_0000 || ovf_o !== exp_ovf || wreg_o !== exp_wreg) begin
            n_fail++;
            $display("FAIL add_ovf: valid=%b wdata=%h ovf=%b wreg=%b want 1 80000000 %b %b", valid_o, wdata_o, ovf_o, wreg_o, exp_ovf, exp_wreg);
        end
        tick();
        n_checks++;
        if (ovf_o !== 1'b0 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_pulse: ovf=%b valid=%b want 0 0", ovf_o, valid_o);
        end
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        test_reset();
        test_back_to_back();
        test_single_cycle_ops();
        test_multu();
        test_divu();
        test_flush();
        test_add_ovf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
